// File: rtl/qbus_dma_arbiter_if.sv
// QBUS DMA arbitration bundle: device request/grant lines plus the CPU DMR/DMGO/SACK handshake.
// All signals are active-high; pin inversion happens at the chip top.
interface qbus_dma_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] dev_req;
  logic [NREQ-1:0] dev_gnt;
  logic            cpu_dmgo;
  logic            bus_sync;
  logic            bus_rply;
  logic            cpu_dmr;
  logic            cpu_sack;
  logic            tmo_err;
  logic            busy;

  modport master (
    input  dev_req, cpu_dmgo, bus_sync, bus_rply,
    output dev_gnt, cpu_dmr, cpu_sack, tmo_err, busy
  );

  modport slave (
    output dev_req, cpu_dmgo, bus_sync, bus_rply,
    input  dev_gnt, cpu_dmr, cpu_sack, tmo_err, busy
  );
endinterface

// File: rtl/qbus_dma_arbiter.sv
// Round-robin QBUS DMA mastership arbiter: folds device requests onto DMR and runs DMR->DMGO->SACK.
// Outputs are registered from the next-state decode, so they change exactly on the transition edge.
module qbus_dma_arbiter #(
  parameter int NREQ  = 4,
  parameter int TMO_W = 8,
  parameter int TMO   = 200
) (
  input logic                 clk,
  input logic                 rst_n,
  qbus_dma_arbiter_if.master  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAITBUS, OWN, REL} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     last, last_n, sel, sel_n, pick;
  logic [TMO_W-1:0]  cnt, cnt_n;
  logic              tmo_n;
  logic [NREQ-1:0]   gnt_n;
  logic              req_sel;

  // Scan downward so the closest set bit after 'last' is the one left in 'pick'.
  always_comb begin
    pick = '0;
    for (int off = NREQ; off >= 1; off--) begin
      if (bus.dev_req[(int'(last) + off) % NREQ])
        pick = IW'((int'(last) + off) % NREQ);
    end
  end

  assign req_sel = bus.dev_req[sel];

  always_comb begin
    state_n = state;
    last_n  = last;
    sel_n   = sel;
    cnt_n   = cnt;
    tmo_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|bus.dev_req) begin
          sel_n   = pick;
          state_n = REQ;
        end
      end
      REQ: begin
        cnt_n = cnt + 1'b1;
        if (!req_sel)
          state_n = IDLE;
        else if (bus.cpu_dmgo)
          state_n = WAITBUS;
        else if (cnt == TMO_W'(TMO - 1)) begin
          // cnt counts completed REQ cycles, so this is the TMO-th cycle without DMGO
          state_n = IDLE;
          tmo_n   = 1'b1;
          last_n  = sel;
        end
      end
      WAITBUS: begin
        if (!req_sel)
          state_n = IDLE;
        else if (!bus.cpu_dmgo)
          state_n = REQ;
        else if (!bus.bus_sync && !bus.bus_rply)
          state_n = OWN;
      end
      OWN: begin
        if (!req_sel) begin
          state_n = REL;
          last_n  = sel;
        end
      end
      REL: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    gnt_n = '0;
    if (state_n == OWN) gnt_n[sel_n] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= IW'(NREQ - 1);
      sel          <= '0;
      cnt          <= '0;
      bus.cpu_dmr  <= 1'b0;
      bus.cpu_sack <= 1'b0;
      bus.dev_gnt  <= '0;
      bus.tmo_err  <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_n;
      last         <= last_n;
      sel          <= sel_n;
      cnt          <= cnt_n;
      bus.cpu_dmr  <= (state_n == REQ) || (state_n == WAITBUS);
      bus.cpu_sack <= (state_n == OWN);
      bus.dev_gnt  <= gnt_n;
      bus.tmo_err  <= tmo_n;
      bus.busy     <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Directed bench for qbus_dma_arbiter: vector table for the basic handshake plus
// hand sequences for round-robin, timeout and mid-tenure reset.
module tb_qbus_dma_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  qbus_dma_arbiter_if #(.NREQ(4)) bus ();

  qbus_dma_arbiter #(.NREQ(4), .TMO_W(8), .TMO(200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic       dmgo, sync, rply;
    logic       dmr, sack;
    logic [3:0] gnt;
    logic       tmo, busy;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.dev_req  = '0;
    bus.cpu_dmgo = 1'b0;
    bus.bus_sync = 1'b0;
    bus.bus_rply = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Handshake invariants, checked every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_sack_gnt", 0, {31'd0, bus.cpu_sack == (bus.dev_gnt != '0)}, 32'd1);
      chk("inv_dmr_sack", 0, {31'd0, !(bus.cpu_dmr && bus.cpu_sack)}, 32'd1);
      chk("inv_onehot",   0, {31'd0, $onehot0(bus.dev_gnt)}, 32'd1);
    end
  end

  initial begin
    logic [3:0] rr_exp [5];
    int low, w, hi, k;

    // single tenure
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[4]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1};
    tbl[5]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    // withdrawal in REQ
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    // bus busy: DMGO with SYNC for 6 cycles, then RPLY lingering one more
    tbl[10] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    for (int i = 11; i <= 16; i++)
      tbl[i] = '{4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[17] = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[18] = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1};
    tbl[19] = '{4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1};
    tbl[20] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[21] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    // DMGO drops while waiting for the bus
    tbl[22] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[23] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[24] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[25] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[26] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1};
    tbl[27] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[28] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

    do_reset();
    chk("rst_dmr",  0, {31'd0, bus.cpu_dmr},  32'd0);
    chk("rst_sack", 0, {31'd0, bus.cpu_sack}, 32'd0);
    chk("rst_gnt",  0, {28'd0, bus.dev_gnt},  32'd0);
    chk("rst_tmo",  0, {31'd0, bus.tmo_err},  32'd0);
    chk("rst_busy", 0, {31'd0, bus.busy},     32'd0);

    for (int i = 0; i < NV; i++) begin
      bus.dev_req  = tbl[i].req;
      bus.cpu_dmgo = tbl[i].dmgo;
      bus.bus_sync = tbl[i].sync;
      bus.bus_rply = tbl[i].rply;
      step();
      chk("vec_dmr",  i, {31'd0, bus.cpu_dmr},  {31'd0, tbl[i].dmr});
      chk("vec_sack", i, {31'd0, bus.cpu_sack}, {31'd0, tbl[i].sack});
      chk("vec_gnt",  i, {28'd0, bus.dev_gnt},  {28'd0, tbl[i].gnt});
      chk("vec_tmo",  i, {31'd0, bus.tmo_err},  {31'd0, tbl[i].tmo});
      chk("vec_busy", i, {31'd0, bus.busy},     {31'd0, tbl[i].busy});
    end

    // round-robin with all four requesting, 5-cycle tenures
    do_reset();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    bus.dev_req  = 4'b1111;
    bus.cpu_dmgo = 1'b1;
    low = 0;
    for (int t = 0; t < 5; t++) begin
      w = 0;
      while (!bus.cpu_sack && w < 20) begin
        step();
        w++;
        if (!bus.cpu_sack) low++;
      end
      chk("rr_sack", t, {31'd0, bus.cpu_sack}, 32'd1);
      chk("rr_gnt",  t, {28'd0, bus.dev_gnt}, {28'd0, rr_exp[t]});
      if (t > 0) chk("rr_gap_ge2", t, {31'd0, low >= 2}, 32'd1);
      repeat (4) step();
      chk("rr_hold", t, {28'd0, bus.dev_gnt}, {28'd0, rr_exp[t]});
      bus.dev_req = bus.dev_req & ~rr_exp[t];
      step();
      chk("rr_rel_sack", t, {31'd0, bus.cpu_sack}, 32'd0);
      low = 1;
      bus.dev_req = bus.dev_req | rr_exp[t];
    end

    // grant timeout: DMGO never arrives
    do_reset();
    bus.dev_req = 4'b0011;
    hi = 0;
    k  = 0;
    while (k < 300 && !bus.tmo_err) begin
      step();
      k++;
      if (bus.cpu_dmr && !bus.tmo_err) hi++;
    end
    chk("tmo_seen",   0, {31'd0, bus.tmo_err}, 32'd1);
    chk("tmo_cycles", 0, hi, 32'd200);
    chk("tmo_dmr",    0, {31'd0, bus.cpu_dmr}, 32'd0);
    step();
    chk("tmo_pulse", 0, {31'd0, bus.tmo_err}, 32'd0);
    chk("tmo_rereq", 0, {31'd0, bus.cpu_dmr}, 32'd1);
    bus.cpu_dmgo = 1'b1;
    step();
    step();
    chk("tmo_skip_gnt", 0, {28'd0, bus.dev_gnt}, 32'h2);

    // asynchronous reset mid-tenure
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sack", 0, {31'd0, bus.cpu_sack}, 32'd0);
    chk("arst_gnt",  0, {28'd0, bus.dev_gnt},  32'd0);
    chk("arst_busy", 0, {31'd0, bus.busy},     32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.dev_req  = 4'b1111;
    bus.cpu_dmgo = 1'b1;
    repeat (3) step();
    chk("arst_first_gnt", 0, {28'd0, bus.dev_gnt}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qbus_dma_arbiter.md
Name: qbus_dma_arbiter

Overview:
- Synthesizable QBUS DMA bus-mastership arbiter for the am4 system.
- Sits between the CPU's DMR/DMGO/SACK pins and up to NREQ on-board DMA masters (disk/DRAM-refresh engines).
- Collapses the per-device requests into the single shared DMR line and runs the DMR -> DMGO -> SACK handshake.
- Grants the bus to exactly one device with round-robin fairness, and aborts requests the CPU never grants.
- All signals are active-high internally; pin inversion (_n) is done at the top level.

Parameters:
NREQ, 4, number of DMA requesters (2..8)
TMO_W, 8, width of the grant-timeout counter
TMO, 200, cycles in REQ without DMGO before abort (1..2^TMO_W-1)

Ports:
clk  in  1  system clock (same as cpu pin_clk)
rst_n  in  1  asynchronous active-low reset
dev_req  in  NREQ  per-device bus request; device holds it high for the whole tenure
dev_gnt  out  NREQ  one-hot grant; device may drive SYNC only while its bit is high
cpu_dmgo  in  1  bus grant from CPU (inverted pin_dmgo_n)
bus_sync  in  1  QBUS SYNC asserted (active-high view)
bus_rply  in  1  QBUS RPLY asserted (active-high view)
cpu_dmr  out  1  DMA request to CPU (to pin_dmr_n, inverted)
cpu_sack  out  1  bus acknowledge to CPU (to pin_sack_n, inverted)
tmo_err  out  1  one-cycle pulse: grant timeout on current request
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cpu_dmr, cpu_sack, dev_gnt, tmo_err, busy all 0.
  - Round-robin pointer last=NREQ-1, so device 0 has first priority; timeout counter cleared.
  - Reset asserted mid-tenure drops sack/gnt immediately, with no REL cycle.
- All outputs are registered and update on the rising edge of clk. All inputs are sampled on the rising edge; no internal synchronizers (the caller provides them).
- IDLE:
  - If any dev_req is set, select sel = first set bit searching upward from last+1, modulo NREQ.
  - Go to REQ; cpu_dmr=1 from the next edge, so latency is 1 cycle from the request edge to DMR.
- REQ (cpu_dmr=1; counter increments each cycle):
  - cpu_dmgo=1 -> WAITBUS.
  - dev_req[sel]=0 (device withdrew) -> IDLE with cpu_dmr=0; last is unchanged.
  - Counter==TMO with no DMGO -> IDLE; tmo_err=1 for one cycle, cpu_dmr=0, last=sel so the pointer skips the failing device.
  - If DMGO and timeout coincide, DMGO wins.
- WAITBUS (cpu_dmr=1): wait until the previous master finishes its cycle.
  - bus_sync=0 && bus_rply=0 -> OWN, with cpu_sack=1, cpu_dmr=0, dev_gnt[sel]=1 all set on the same edge.
  - cpu_dmgo drops before the bus is idle -> back to REQ; the counter continues and is not cleared.
  - dev_req[sel]=0 -> IDLE, as in REQ.
- OWN (cpu_sack=1, dev_gnt=onehot(sel)):
  - Stay while dev_req[sel]=1; there is no tenure limit.
  - Requests from other devices are ignored until the bus is released.
  - dev_req[sel]=0 -> REL.
- REL:
  - cpu_sack=0, dev_gnt=0, last=sel, counter cleared.
  - Always exactly one cycle, then IDLE.
  - A new request arbitrates in IDLE on the following cycle, so the minimum bus turnaround is 2 cycles (SACK low for at least 2 cycles between tenures).
- Invariants:
  - dev_gnt is zero or one-hot.
  - cpu_sack=1 if and only if dev_gnt≠0.
  - cpu_dmr and cpu_sack are never both 1.
  - dev_gnt is only asserted after DMGO was seen with the bus idle.
- NREQ=1: the round-robin degenerates and the pointer is ignored.

Test Plan:
- Single request: dev_req=0001; DMGO returned 3 cycles after cpu_dmr; sync=rply=0.
  -> cpu_dmr rises 1 cycle after the request and falls on the same edge that sets cpu_sack=1 and dev_gnt=0001.
  -> After dev_req drops: 1 REL cycle, then sack=0 and gnt=0.
- Round-robin: dev_req=1111 held and each tenure released after 5 cycles.
  -> Grants go in the order 0001, 0010, 0100, 1000, 0001.
  -> SACK is low for at least 2 cycles between tenures.
- Bus-busy: DMGO arrives while bus_sync=1 for 6 more cycles.
  -> cpu_sack stays 0 and cpu_dmr stays 1 until the cycle after sync=rply=0, then sack=1.
- Timeout: TMO=200, dev_req=0011, DMGO never asserted.
  -> After 200 REQ cycles: tmo_err pulses 1 cycle and cpu_dmr=0.
  -> Device 1 is then selected, showing the pointer skipped device 0.
- Withdrawal and reset: dev_req drops in REQ -> IDLE with no pulse and no grant. Reset asserted in OWN -> sack and gnt clear asynchronously; after release, device 0 wins first.
